mul_div_ctrl: RTL
=================

Name: mul_div_ctrl

Overview:
- Sequencing controller for the EX-stage multiply/divide resource.
- Accepts one mul/div op per instruction from EX and holds its operands stable for the whole operation.
- Drives an external pipelined multiplier and runs an internal radix-2 restoring divider.
- Raises the stall requests that freeze the pipeline, then presents the 32-bit result exactly once per instruction, honouring stall and flush.

Parameters:
- MUL_LAT, 2, cycles from mul_start sample to mul_prod valid (1..4).
- DIV_ITER, 32, divider iterations, one quotient bit per cycle.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- stall  in  6  pipeline stall vector; stall[2] = EX held
- flush  in  1  cancel in-flight op (exception/branch)
- op_valid  in  1  EX holds a mul/div instruction
- op_div  in  1  1 = divide, 0 = multiply
- sign_flag  in  1  signed operation
- rem_flag  in  1  div: return remainder
- high_flag  in  1  mul: return product[63:32]
- a  in  32  operand A / dividend
- b  in  32  operand B / divisor
- mul_prod  in  64  external multiplier product
- mul_start  out  1  one-cycle pulse launching the multiplier
- mul_a  out  32  multiplier operand A, held stable
- mul_b  out  32  multiplier operand B, held stable
- mul_signed  out  1  multiplier signedness
- stallreq_for_mul  out  1  multiply in progress
- stallreq_for_div  out  1  divide in progress
- result  out  32  final result, valid when result_valid = 1
- result_valid  out  1  result available to EX

Behaviour:
- All state changes on posedge clk. Reset and flush are synchronous.
- Reset: state IDLE, counters 0, all operand/result registers 0. All outputs read 0: mul_start, stallreq_*, result, result_valid, mul_a, mul_b, mul_signed.
- States: IDLE, MUL_WAIT, DIV_RUN, DONE.
- IDLE, op_valid = 1 and flush = 0 (accept cycle T):
  - Capture a, b and all flags into registers.
  - Assert the matching stallreq combinationally in cycle T.
  - Mul: mul_start = 1 in T, with mul_a/mul_b driven from the live a/b inputs; go to MUL_WAIT.
  - Div: capture |a| and |b| (magnitudes only if sign_flag), plus the quotient and remainder signs; go to DIV_RUN.
- MUL_WAIT:
  - Counts MUL_LAT cycles; mul_a/mul_b come from the registered operands.
  - At the end of cycle T+MUL_LAT, register mul_prod[63:32] if high_flag, else mul_prod[31:0], into result; go to DONE.
  - stallreq_for_mul is high in T..T+MUL_LAT.
- DIV_RUN:
  - One restoring step per cycle, counter 0..DIV_ITER-1.
  - After the last step, apply sign fixup: quotient negated if the signs of a and b differ; remainder takes the sign of a.
  - Register the quotient, or the remainder if rem_flag; go to DONE.
  - stallreq_for_div is high in T..T+DIV_ITER.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = a. No trap.
- Signed 0x80000000 / -1: quotient 0x80000000, remainder 0.
- DONE:
  - result_valid = 1 and stallreq_* = 0.
  - Stays in DONE while stall[2] = 1. op_valid staying high for the same instruction must NOT restart the operation.
  - Returns to IDLE on the first cycle with stall[2] = 0; result_valid drops the next cycle.
  - A back-to-back mul/div can therefore be accepted no earlier than the cycle after leaving DONE.
- Flush:
  - Has priority over everything except reset.
  - Forces all stallreq_* low combinationally in the same cycle; state IDLE next cycle.
  - result_valid clears; an in-flight divide is abandoned.
- Ignored inputs: op_valid with flush = 1 in IDLE. Operand changes on a/b after the accept cycle.
- stallreq_for_mul and stallreq_for_div are never high together.

Decomposition:
- Shared package mul_div_pkg:
  - State encoding (2-bit localparams IDLE/MUL_WAIT/DIV_RUN/DONE).
  - DIV_ITER constant.
  - Divide-by-zero quotient constant 0xFFFFFFFF.
- One sub-module, div_radix2_step: combinational restoring step taking remainder/quotient regs and divisor, returning next remainder/quotient. The iteration registers stay in mul_div_ctrl.

Test Plan:
- Signed mul a=-3, b=7, high_flag=0, MUL_LAT=2 -> stallreq_for_mul high 3 cycles, result=0xFFFFFFEB with result_valid in cycle T+3.
- Signed div a=-7, b=2, rem_flag=0 then rem_flag=1 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. stallreq_for_div high exactly 33 cycles.
- Unsigned div a=5, b=0 -> result 0xFFFFFFFF. Signed 0x80000000 / 0xFFFFFFFF -> 0x80000000, rem 0.
- In DONE hold stall[2]=1 for 4 cycles with op_valid high -> result_valid held, no new mul_start, stallreq low, result unchanged.
- flush asserted at iteration 10 of a divide -> stallreq_for_div low that cycle, IDLE next, no result_valid. A new mul is accepted the cycle after.
- reset asserted mid-MUL_WAIT -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared encodings and constants for the EX-stage multiply/divide controller.
package mul_div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_RUN  = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int          DIV_ITER   = 32;
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    // Two's-complement negate when n is set; used for magnitudes and sign fixup.
    function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
        return n ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_radix2_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module div_radix2_step (
    input  logic [31:0] rem_in,
    input  logic [31:0] quo_in,
    input  logic [31:0] divisor,
    output logic [31:0] rem_out,
    output logic [31:0] quo_out
);

    logic [32:0] shifted;
    logic [32:0] trial;

    // Partial remainder stays below the divisor, so a successful trial always
    // fits back in 32 bits and bit 32 of the trial is a clean borrow flag.
    always_comb begin
        shifted = {rem_in, quo_in[31]};
        trial   = shifted - {1'b0, divisor};
        if (trial[32]) begin
            rem_out = shifted[31:0];
            quo_out = {quo_in[30:0], 1'b0};
        end else begin
            rem_out = trial[31:0];
            quo_out = {quo_in[30:0], 1'b1};
        end
    end

endmodule

// File: rtl/mul_div_ctrl.sv
// EX-stage mul/div sequencer: launches the external pipelined multiplier or
// runs the iterative divider, stalls the pipe, and presents one result.
module mul_div_ctrl #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        op_valid,
    input  logic        op_div,
    input  logic        sign_flag,
    input  logic        rem_flag,
    input  logic        high_flag,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [63:0] mul_prod,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_signed,
    output logic        stallreq_for_mul,
    output logic        stallreq_for_div,
    output logic [31:0] result,
    output logic        result_valid
);
    import mul_div_pkg::*;

    localparam int CNT_W = $clog2(DIV_ITER + MUL_LAT + 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        a_r, b_r;
    logic               sign_r, rem_r, high_r;
    logic [31:0]        rem_acc, quo_acc, dsr;
    logic [31:0]        rem_nx, quo_nx;
    logic               q_neg, r_neg, dz;
    logic               accept, mul_last, div_last;
    logic [31:0]        div_res;
    logic               unused_stall;

    // Only the EX-hold bit of the stall vector matters to this block.
    assign unused_stall = ^{stall[5:3], stall[1:0]};

    div_radix2_step u_step (
        .rem_in  (rem_acc),
        .quo_in  (quo_acc),
        .divisor (dsr),
        .rem_out (rem_nx),
        .quo_out (quo_nx)
    );

    assign accept   = (state == IDLE) && op_valid && !flush && !reset;
    assign mul_last = (state == MUL_WAIT) && (cnt == CNT_W'(MUL_LAT - 1));
    assign div_last = (state == DIV_RUN) && (cnt == CNT_W'(DIV_ITER - 1));

    // Final divide value: zero-divisor results bypass the sign fixup.
    always_comb begin
        div_res = '0;
        if (dz)         div_res = rem_r ? a_r : DIV_ZERO_Q;
        else if (rem_r) div_res = neg_if(r_neg, rem_nx);
        else            div_res = neg_if(q_neg, quo_nx);
    end

    // Next state and combinational outputs; flush overrides every transition.
    always_comb begin
        state_n          = state;
        mul_start        = accept && !op_div;
        stallreq_for_mul = !flush && !reset && ((accept && !op_div) || state == MUL_WAIT);
        stallreq_for_div = !flush && !reset && ((accept && op_div) || state == DIV_RUN);
        mul_a            = mul_start ? a : a_r;
        mul_b            = mul_start ? b : b_r;
        mul_signed       = mul_start ? sign_flag : sign_r;
        result_valid     = (state == DONE);
        unique case (state)
            IDLE:     if (accept) state_n = op_div ? DIV_RUN : MUL_WAIT;
            MUL_WAIT: if (mul_last) state_n = DONE;
            DIV_RUN:  if (div_last) state_n = DONE;
            DONE:     if (!stall[2]) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Operand capture, iteration counter, divider accumulators and result.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            sign_r  <= 1'b0;
            rem_r   <= 1'b0;
            high_r  <= 1'b0;
            rem_acc <= '0;
            quo_acc <= '0;
            dsr     <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            dz      <= 1'b0;
            result  <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept) begin
                        a_r     <= a;
                        b_r     <= b;
                        sign_r  <= sign_flag;
                        rem_r   <= rem_flag;
                        high_r  <= high_flag;
                        rem_acc <= '0;
                        quo_acc <= neg_if(sign_flag && a[31], a);
                        dsr     <= neg_if(sign_flag && b[31], b);
                        q_neg   <= sign_flag && (a[31] ^ b[31]);
                        r_neg   <= sign_flag && a[31];
                        dz      <= (b == 32'd0);
                    end
                end
                MUL_WAIT: begin
                    cnt <= mul_last ? '0 : cnt + 1'b1;
                    if (mul_last) result <= high_r ? mul_prod[63:32] : mul_prod[31:0];
                end
                DIV_RUN: begin
                    cnt     <= div_last ? '0 : cnt + 1'b1;
                    rem_acc <= rem_nx;
                    quo_acc <= quo_nx;
                    if (div_last) result <= div_res;
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule
